i2c_slave_reg: RTL and testbench
================================

Name: i2c_slave_reg

Overview:
- I2C target (responder) holding one 8-bit data register; it is the counterpart of the on-board I2C master used by the self-test FSM.
- Accepts write transactions that load the register and read transactions that return it.
- Runs oversampled on the system clock. SDA uses open-drain signalling: the enclosing top converts sda_oe into the tristate pad.
- Answers only to its own 7-bit address.

Parameters:
- SLAVE_ADDR, 7'h55, 7-bit address this target acknowledges.
- INIT_DATA, 8'h00, reset value of the data register.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- scl_in  input  1  SCL pad value (asynchronous).
- sda_in  input  1  SDA pad value (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- stored_data  output  8  current data register contents.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset: state IDLE, sda_oe=0, rx_valid=0, busy=0, rx_data=8'h00, stored_data=INIT_DATA, shift and bit counters 0, synchronizers loaded with 1.
- Input conditioning:
  - 2-FF synchronizer on scl_in and on sda_in, plus one delayed copy of each for edge detection.
  - The block therefore responds 2-3 clk after a pad change.
  - SCL rise/fall = synchronized-level edge.
- START = sync SDA falls while sync SCL is high. STOP = sync SDA rises while sync SCL is high.
- In any state:
  - START -> ADDR: bit counter cleared, sda_oe=0.
  - STOP -> IDLE: sda_oe=0.
  - START/STOP take priority over bit handling in the same clk.
- Data bits are sampled on SCL rise, MSB first. sda_oe changes only on SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on SCL rises. On the SCL fall after the 8th bit:
    - if bits[7:1]==SLAVE_ADDR: latch rw=bit0, sda_oe=1, go to ADDR_ACK.
    - otherwise go to WAIT_STOP with sda_oe=0.
  - ADDR_ACK: ACK is held low for one full SCL period. On the next SCL fall:
    - rw=0: sda_oe=0, go to WR_DATA.
    - rw=1: sda_oe=~stored_data[7], go to RD_DATA.
  - WR_DATA: shift 8 bits. On the SCL fall after the 8th bit:
    - stored_data and rx_data <= shifted byte; rx_valid=1 for exactly one clk.
    - sda_oe=1, go to WR_ACK.
  - WR_ACK: on the next SCL fall, sda_oe=0 and go back to WR_DATA. Consecutive written bytes each overwrite the register.
  - RD_DATA: on each SCL fall, present the next bit (sda_oe=~bit). On the SCL fall after the 8th bit, sda_oe=0 and go to RD_ACK.
  - RD_ACK: sample the master's bit on SCL rise.
    - 0 (ACK): on the next SCL fall, present stored_data[7] again and return to RD_DATA. The same byte repeats.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0; wait for STOP, or for START (repeated start).
- The bit counter is 3 bits and wraps 7->0 at each byte boundary.
- The target never drives SDA high and never stretches SCL.
- Reset mid-transaction releases SDA immediately (asynchronous).
- A write arriving during a read is impossible on the bus. A repeated START after a write switches direction without passing through IDLE.
- stored_data changes only on a completed 8-bit write byte. A write aborted by START or STOP mid-byte leaves it unchanged.

Test Plan:
- Write 0x55/W, byte 0xAA, STOP -> ACK low on the 9th SCL of the address and data bytes; rx_valid single pulse; rx_data=stored_data=8'hAA; busy drops after STOP.
- After the above, read 0x55/R, master NACK, STOP -> SDA carries 1010_1010 MSB first; sda_oe=0 during the NACK bit.
- Address 0x22/W, byte 0x33 -> no ACK (sda_oe stays 0 throughout), stored_data unchanged, state WAIT_STOP until STOP.
- Read with master ACK on byte 1, NACK on byte 2 -> both bytes equal stored_data (INIT_DATA=8'h00 after reset).
- Write 0x55/W then repeated START with 0x55/R, no STOP in between -> address re-ACKed; read returns the just-written byte.
- Assert reset while the target drives an ACK -> sda_oe=0 within the same clk; busy=0; stored_data=INIT_DATA.

Source files
------------

// File: rtl/i2c_slave_reg.sv
// I2C target holding a single 8-bit register: writes to SLAVE_ADDR load it, reads return it.
// Runs oversampled on clk; sda_oe=1 pulls SDA low, the enclosing top builds the open-drain pad.
module i2c_slave_reg #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter logic [7:0] INIT_DATA  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] stored_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    logic   scl_meta_r, scl_sync_r, scl_prev_r;
    logic   sda_meta_r, sda_sync_r, sda_prev_r;
    state_t state_r, state_nx_s;
    logic   busy_r;
    logic [7:0] shift_r, shift_nx_s;
    logic [2:0] cnt_r, cnt_nx_s;
    logic   byte_done_r, done_nx_s;
    logic   rw_r, rw_nx_s;
    logic   sda_oe_r, sda_oe_nx_s;
    logic [7:0] rx_data_r, rx_data_nx_s;
    logic   rx_valid_r, rx_valid_nx_s;
    logic [7:0] stored_r, stored_nx_s;

    logic scl_rise_s, scl_fall_s, start_s, stop_s;

    assign scl_rise_s = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r & scl_prev_r;
    assign start_s    = scl_sync_r & sda_prev_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & ~sda_prev_r & sda_sync_r;

    // Pad synchronizers plus one delayed copy for edge detection (idle bus level is 1)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // State register; busy is registered alongside so it tracks state exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Next-state logic; bus conditions override any bit handling in the same cycle
    always_comb begin
        state_nx_s = state_r;
        if (start_s) begin
            state_nx_s = ADDR;
        end else if (stop_s) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE:      state_nx_s = IDLE;
                ADDR: begin
                    if (scl_fall_s && byte_done_r) begin
                        state_nx_s = (shift_r[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                    end else begin
                        state_nx_s = ADDR;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        state_nx_s = rw_r ? RD_DATA : WR_DATA;
                    end else begin
                        state_nx_s = ADDR_ACK;
                    end
                end
                WR_DATA:   state_nx_s = (scl_fall_s && byte_done_r) ? WR_ACK : WR_DATA;
                WR_ACK:    state_nx_s = scl_fall_s ? WR_DATA : WR_ACK;
                RD_DATA:   state_nx_s = (scl_fall_s && byte_done_r) ? RD_ACK : RD_DATA;
                RD_ACK: begin
                    if (scl_rise_s && sda_sync_r) begin
                        state_nx_s = WAIT_STOP;
                    end else if (scl_fall_s && byte_done_r) begin
                        state_nx_s = RD_DATA;
                    end else begin
                        state_nx_s = RD_ACK;
                    end
                end
                WAIT_STOP: state_nx_s = WAIT_STOP;
                default:   state_nx_s = IDLE;
            endcase
        end
    end

    // Datapath/output next values: bits shift on SCL rise, SDA drive only moves on SCL fall.
    // byte_done marks "8th bit sampled" (or master ACK seen in RD_ACK) so the following fall acts.
    always_comb begin
        shift_nx_s    = shift_r;
        cnt_nx_s      = cnt_r;
        done_nx_s     = byte_done_r;
        rw_nx_s       = rw_r;
        sda_oe_nx_s   = sda_oe_r;
        rx_data_nx_s  = rx_data_r;
        rx_valid_nx_s = 1'b0;
        stored_nx_s   = stored_r;
        if (start_s || stop_s) begin
            sda_oe_nx_s = 1'b0;
            cnt_nx_s    = 3'd0;
            done_nx_s   = 1'b0;
        end else begin
            case (state_r)
                ADDR, WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_nx_s = {shift_r[6:0], sda_sync_r};
                        cnt_nx_s   = cnt_r + 3'd1;
                        done_nx_s  = (cnt_r == 3'd7);
                    end else if (scl_fall_s && byte_done_r) begin
                        done_nx_s = 1'b0;
                        if (state_r == WR_DATA) begin
                            stored_nx_s   = shift_r;
                            rx_data_nx_s  = shift_r;
                            rx_valid_nx_s = 1'b1;
                            sda_oe_nx_s   = 1'b1;
                        end else if (shift_r[7:1] == SLAVE_ADDR) begin
                            rw_nx_s     = shift_r[0];
                            sda_oe_nx_s = 1'b1;
                        end else begin
                            sda_oe_nx_s = 1'b0;
                        end
                    end else begin
                        shift_nx_s = shift_r;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_nx_s = rw_r ? ~stored_r[7] : 1'b0;
                        cnt_nx_s    = 3'd0;
                    end else begin
                        sda_oe_nx_s = sda_oe_r;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_nx_s = 1'b0;
                    end else begin
                        sda_oe_nx_s = sda_oe_r;
                    end
                end
                RD_DATA: begin
                    if (scl_rise_s) begin
                        cnt_nx_s  = cnt_r + 3'd1;
                        done_nx_s = (cnt_r == 3'd7);
                    end else if (scl_fall_s && byte_done_r) begin
                        sda_oe_nx_s = 1'b0;
                        done_nx_s   = 1'b0;
                    end else if (scl_fall_s) begin
                        sda_oe_nx_s = ~stored_r[~cnt_r];
                    end else begin
                        sda_oe_nx_s = sda_oe_r;
                    end
                end
                RD_ACK: begin
                    if (scl_rise_s) begin
                        done_nx_s = ~sda_sync_r;
                    end else if (scl_fall_s && byte_done_r) begin
                        done_nx_s   = 1'b0;
                        cnt_nx_s    = 3'd0;
                        sda_oe_nx_s = ~stored_r[7];
                    end else begin
                        done_nx_s = byte_done_r;
                    end
                end
                WAIT_STOP: sda_oe_nx_s = 1'b0;
                IDLE:      sda_oe_nx_s = 1'b0;
                default:   sda_oe_nx_s = 1'b0;
            endcase
        end
    end

    // Datapath/output registers; reset releases SDA immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r     <= 8'h00;
            cnt_r       <= 3'd0;
            byte_done_r <= 1'b0;
            rw_r        <= 1'b0;
            sda_oe_r    <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            stored_r    <= INIT_DATA;
        end else begin
            shift_r     <= shift_nx_s;
            cnt_r       <= cnt_nx_s;
            byte_done_r <= done_nx_s;
            rw_r        <= rw_nx_s;
            sda_oe_r    <= sda_oe_nx_s;
            rx_data_r   <= rx_data_nx_s;
            rx_valid_r  <= rx_valid_nx_s;
            stored_r    <= stored_nx_s;
        end
    end

    assign sda_oe      = sda_oe_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign stored_data = stored_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_i2c_slave_reg.sv
// Bench for i2c_slave_reg: a bit-banged bus master with wired-AND SDA, a vector table,
// hand-written corner sequences and random transactions against a register-level model.
module tb_i2c_slave_reg;

    localparam logic [6:0] SA   = 7'h55;
    localparam logic [7:0] INIT = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] stored_data;
    logic       busy;
    wire        sda_line = sda_m & ~sda_oe;

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;
    int rx_wide  = 0;
    logic rx_prev = 1'b0;

    logic       aack;
    logic [7:0] rb [2];
    logic       dack [2];
    logic       oe_mack;
    logic       busy_pre;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        int         n;
        logic       exp_ack;
        logic [7:0] exp_rd;
        logic [7:0] exp_stored;
    } vec_t;
    vec_t tbl [9];

    i2c_slave_reg #(.SLAVE_ADDR(SA), .INIT_DATA(INIT)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .stored_data(stored_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (rx_valid && rx_prev) rx_wide <= rx_wide + 1;
        rx_prev <= rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic q();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic start_cond();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic rep_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic send_bit(input logic b, output logic line, output logic oe);
        sda_m = b;    q();
        scl_m = 1'b1; q();
        line = sda_line;
        oe   = sda_oe;
        q();
        scl_m = 1'b0; q();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic l, o;
        for (int i = 7; i >= 0; i--) send_bit(b[i], l, o);
        send_bit(1'b1, l, o);
        ack = ~l;
    endtask

    task automatic rd_byte(input logic last, output logic [7:0] d, output logic oe_m);
        logic l, o;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, l, o);
            d[i] = l;
        end
        send_bit(last, l, o);
        oe_m = o;
    endtask

    task automatic txn(input logic [6:0] addr, input logic rw, input logic [7:0] wb0,
                       input logic [7:0] wb1, input int n, input bit rep, input bit do_stop);
        logic o;
        oe_mack = 1'b0;
        if (rep) rep_start(); else start_cond();
        wr_byte({addr, rw}, aack);
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                wr_byte((i == 0) ? wb0 : wb1, dack[i]);
            end else begin
                rd_byte(i == n - 1, rb[i], o);
                oe_mack = oe_mack | o;
            end
        end
        busy_pre = busy;
        if (do_stop) begin
            stop_cond();
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] ref_reg;
        int exp_rx;
        int base_rx;
        logic       l, o;

        tbl[0] = '{7'h55, 1'b0, 8'hAA, 1, 1'b1, 8'h00, 8'hAA};
        tbl[1] = '{7'h55, 1'b1, 8'h00, 1, 1'b1, 8'hAA, 8'hAA};
        tbl[2] = '{7'h22, 1'b0, 8'h33, 1, 1'b0, 8'h00, 8'hAA};
        tbl[3] = '{7'h55, 1'b0, 8'h3C, 1, 1'b1, 8'h00, 8'h3C};
        tbl[4] = '{7'h2A, 1'b1, 8'h00, 1, 1'b0, 8'hFF, 8'h3C};
        tbl[5] = '{7'h55, 1'b1, 8'h00, 2, 1'b1, 8'h3C, 8'h3C};
        tbl[6] = '{7'h54, 1'b0, 8'hFF, 1, 1'b0, 8'h00, 8'h3C};
        tbl[7] = '{7'h55, 1'b0, 8'h00, 1, 1'b1, 8'h00, 8'h00};
        tbl[8] = '{7'h55, 1'b1, 8'h00, 1, 1'b1, 8'h00, 8'h00};

        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_stored", 32'(stored_data), 32'(INIT));
        reset = 1'b0;
        q();

        // Read INIT_DATA twice: master ACKs byte 1, NACKs byte 2
        txn(SA, 1'b1, 8'h00, 8'h00, 2, 1'b0, 1'b1);
        check("init_rd_aack", 32'(aack), 32'd1);
        check("init_rd_b0", 32'(rb[0]), 32'(INIT));
        check("init_rd_b1", 32'(rb[1]), 32'(INIT));
        check("init_rd_oe_mack", 32'(oe_mack), 32'd0);
        check("init_rd_busy", 32'(busy), 32'd0);

        // Table-driven transactions
        base_rx = rx_cnt;
        exp_rx  = 0;
        for (int i = 0; i < 9; i++) begin
            txn(tbl[i].addr, tbl[i].rw, tbl[i].data, tbl[i].data, tbl[i].n, 1'b0, 1'b1);
            check($sformatf("t%0d_addr_ack", i), 32'(aack), 32'(tbl[i].exp_ack));
            check($sformatf("t%0d_busy_pre_stop", i), 32'(busy_pre), 32'd1);
            if (tbl[i].rw) begin
                for (int j = 0; j < tbl[i].n; j++)
                    check($sformatf("t%0d_rd_b%0d", i, j), 32'(rb[j]), 32'(tbl[i].exp_rd));
                check($sformatf("t%0d_oe_mack", i), 32'(oe_mack), 32'd0);
            end else begin
                check($sformatf("t%0d_data_ack", i), 32'(dack[0]), 32'(tbl[i].exp_ack));
                if (tbl[i].exp_ack) begin
                    exp_rx++;
                    check($sformatf("t%0d_rx_data", i), 32'(rx_data), 32'(tbl[i].data));
                end else begin
                    check($sformatf("t%0d_sda_oe_idle", i), 32'(sda_oe), 32'd0);
                end
            end
            check($sformatf("t%0d_stored", i), 32'(stored_data), 32'(tbl[i].exp_stored));
            check($sformatf("t%0d_busy_after_stop", i), 32'(busy), 32'd0);
        end
        check("tbl_rx_pulses", 32'(rx_cnt - base_rx), 32'(exp_rx));

        // Write then repeated START into a read, no STOP between
        txn(SA, 1'b0, 8'h5A, 8'h00, 1, 1'b0, 1'b0);
        check("rs_wr_aack", 32'(aack), 32'd1);
        check("rs_wr_dack", 32'(dack[0]), 32'd1);
        check("rs_wr_stored", 32'(stored_data), 32'h5A);
        txn(SA, 1'b1, 8'h00, 8'h00, 1, 1'b1, 1'b1);
        check("rs_rd_aack", 32'(aack), 32'd1);
        check("rs_rd_b0", 32'(rb[0]), 32'h5A);
        check("rs_busy", 32'(busy), 32'd0);

        // Write aborted by STOP after four data bits leaves the register alone
        start_cond();
        wr_byte({SA, 1'b0}, l);
        for (int i = 0; i < 4; i++) send_bit(1'b1, l, o);
        stop_cond();
        repeat (8) @(posedge clk);
        #1;
        check("abort_stored", 32'(stored_data), 32'h5A);
        check("abort_busy", 32'(busy), 32'd0);

        // Random transactions against the register model
        ref_reg = 8'h5A;
        base_rx = rx_cnt;
        exp_rx  = 0;
        for (int k = 0; k < 16; k++) begin
            logic [6:0] a;
            logic       rw;
            logic [7:0] w0, w1;
            logic       ea;
            int         n;
            a  = ($urandom_range(0, 1) == 0) ? SA : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            w0 = 8'($urandom_range(0, 255));
            w1 = 8'($urandom_range(0, 255));
            n  = $urandom_range(1, 2);
            ea = (a == SA);
            txn(a, rw, w0, w1, n, 1'b0, 1'b1);
            check($sformatf("r%0d_aack", k), 32'(aack), 32'(ea));
            for (int j = 0; j < n; j++) begin
                if (rw) begin
                    check($sformatf("r%0d_rd_b%0d", k, j), 32'(rb[j]), ea ? 32'(ref_reg) : 32'hFF);
                end else begin
                    check($sformatf("r%0d_dack%0d", k, j), 32'(dack[j]), 32'(ea));
                    if (ea) begin
                        ref_reg = (j == 0) ? w0 : w1;
                        exp_rx++;
                    end
                end
            end
            check($sformatf("r%0d_stored", k), 32'(stored_data), 32'(ref_reg));
            check($sformatf("r%0d_busy", k), 32'(busy), 32'd0);
        end
        check("rnd_rx_pulses", 32'(rx_cnt - base_rx), 32'(exp_rx));
        check("rx_pulse_width", 32'(rx_wide), 32'd0);

        // Reset asserted while the target drives the address ACK
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(((i == 0) ? 1'b0 : SA[i-1]), l, o);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        check("ack_driven_before_reset", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stored", 32'(stored_data), 32'(INIT));
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        q();
        txn(SA, 1'b1, 8'h00, 8'h00, 1, 1'b0, 1'b1);
        check("post_reset_rd", 32'(rb[0]), 32'(INIT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
